// File: rtl/slide_scan_pkg.sv
// Shared types and defaults for the potentiometer scanner.
// Imported by the scanner core and the bus interface.
package slide_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam int RES_W_DEF  = 12;
    localparam int CHNL_W_DEF = 3;

    // Slot 0 in the LSBs; slot 5 reads A2D channel 7.
    localparam logic [17:0] CH_MAP_DEF = {3'd7, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

endpackage

// File: rtl/slide_scan_if.sv
// Conversion handshake between the scanner (master) and the A2D SPI block (slave).
interface slide_scan_if #(
    parameter int RES_W  = slide_scan_pkg::RES_W_DEF,
    parameter int CHNL_W = slide_scan_pkg::CHNL_W_DEF
);
    logic              strt_cnv;
    logic [CHNL_W-1:0] chnnl;
    logic              cnv_cmplt;
    logic [RES_W-1:0]  res;

    modport master (output strt_cnv, output chnnl, input cnv_cmplt, input res);
    modport slave  (input strt_cnv, input chnnl, output cnv_cmplt, output res);
endinterface

// File: rtl/slide_accum.sv
// Per-slot sample accumulator: sums 2^AVG_LOG2 results and exposes the truncated mean.
// 'avg' already includes the sample being presented on din, so it is valid on the last add.
module slide_accum #(
    parameter int RES_W    = 12,
    parameter int AVG_LOG2 = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             add,
    input  logic [RES_W-1:0] din,
    output logic             last,
    output logic [RES_W-1:0] avg
);
    localparam int SUM_W = RES_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    logic [SUM_W-1:0] acc_reg;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] cnt_reg;

    assign sum  = acc_reg + SUM_W'(din);
    assign last = (cnt_reg == CNT_W'((1 << AVG_LOG2) - 1));
    assign avg  = RES_W'(sum >> AVG_LOG2);

    // A clear wins over an add so an abandoned batch never leaks into the next one.
    always_ff @(posedge clk) begin
        if (rst || clr || (add && last)) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (add) begin
            acc_reg <= sum;
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end
endmodule

// File: rtl/slide_scan.sv
// Round-robin slider scanner: requests conversions over a channel map, averages,
// stores one result per slot and recovers from a converter that never answers.
module slide_scan
    import slide_scan_pkg::*;
#(
    parameter int                        NUM_CH   = 6,
    parameter int                        RES_W    = RES_W_DEF,
    parameter int                        CHNL_W   = CHNL_W_DEF,
    parameter logic [NUM_CH*CHNL_W-1:0]  CH_MAP   = CH_MAP_DEF,
    parameter int                        AVG_LOG2 = 0,
    parameter int                        HOLDOFF  = 0,
    parameter int                        TIMEOUT  = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    slide_scan_if.master            a2d,
    output logic [NUM_CH*RES_W-1:0] pot,
    output logic [NUM_CH-1:0]       pot_upd,
    output logic                    scan_done,
    output logic                    timeout
);
    localparam int SLOT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    state_t              state_reg, state_next;
    logic [SLOT_W-1:0]   slot_reg, slot_next;
    logic [WCNT_W-1:0]   wait_cnt_reg;
    logic [7:0]          gap_cnt_reg;
    logic [RES_W-1:0]    pot_reg [NUM_CH];
    logic [NUM_CH-1:0]   pot_upd_reg;
    logic                scan_done_reg, timeout_reg;
    logic [CHNL_W-1:0]   ch_arr [NUM_CH];

    logic                acc_last;
    logic [RES_W-1:0]    acc_avg;
    logic                cmplt_hit, to_hit, resolve, batch_write, slot_adv, slot_wrap, acc_clr;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_slot
            assign ch_arr[gi]               = CH_MAP[gi*CHNL_W +: CHNL_W];
            assign pot[gi*RES_W +: RES_W]   = pot_reg[gi];
        end
    endgenerate

    assign a2d.strt_cnv = (state_reg == START);
    assign a2d.chnnl    = ch_arr[slot_reg];
    assign pot_upd      = pot_upd_reg;
    assign scan_done    = scan_done_reg;
    assign timeout      = timeout_reg;

    // A completion on the final WAIT cycle takes precedence over the timeout.
    assign cmplt_hit   = (state_reg == WAIT) && a2d.cnv_cmplt;
    assign to_hit      = (state_reg == WAIT) && !a2d.cnv_cmplt &&
                         (wait_cnt_reg == WCNT_W'(TIMEOUT - 1));
    assign resolve     = cmplt_hit || to_hit;
    assign batch_write = cmplt_hit && acc_last;
    assign slot_adv    = batch_write || to_hit;
    assign slot_wrap   = slot_adv && (slot_reg == SLOT_W'(NUM_CH - 1));
    assign acc_clr     = to_hit || (cmplt_hit && !acc_last && !en);
    assign slot_next   = slot_wrap ? '0 : (slot_adv ? slot_reg + SLOT_W'(1) : slot_reg);

    slide_accum #(
        .RES_W    (RES_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_accum (
        .clk  (clk),
        .rst  (rst),
        .clr  (acc_clr),
        .add  (cmplt_hit),
        .din  (a2d.res),
        .last (acc_last),
        .avg  (acc_avg)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (en) state_next = START;
            START: state_next = WAIT;
            WAIT: begin
                if (resolve) begin
                    if (!en)              state_next = IDLE;
                    else if (HOLDOFF > 0) state_next = GAP;
                    else                  state_next = START;
                end
            end
            GAP: begin
                if (!en)                                   state_next = IDLE;
                else if (gap_cnt_reg == 8'(HOLDOFF - 1))   state_next = START;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            slot_reg      <= '0;
            wait_cnt_reg  <= '0;
            gap_cnt_reg   <= '0;
            pot_upd_reg   <= '0;
            scan_done_reg <= 1'b0;
            timeout_reg   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) pot_reg[i] <= '0;
        end else begin
            state_reg     <= state_next;
            slot_reg      <= slot_next;
            wait_cnt_reg  <= (state_reg == WAIT) ? wait_cnt_reg + WCNT_W'(1) : '0;
            gap_cnt_reg   <= (state_reg == GAP) ? gap_cnt_reg + 8'd1 : 8'd0;
            scan_done_reg <= slot_wrap;
            timeout_reg   <= to_hit;
            pot_upd_reg   <= '0;
            if (batch_write) begin
                pot_reg[slot_reg]     <= acc_avg;
                pot_upd_reg[slot_reg] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_slide_scan.sv
// Directed bench for slide_scan: three instances cover default scanning, 4-sample
// averaging, and holdoff/timeout/enable handling; one line printed per check.
module tb_slide_scan;
    import slide_scan_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic en_a, en_b, en_c;
    logic [71:0] pot_a, pot_b, pot_c;
    logic [5:0]  upd_a, upd_b, upd_c;
    logic        done_a, done_b, done_c;
    logic        to_a, to_b, to_c;

    slide_scan_if #(.RES_W(12), .CHNL_W(3)) bus_a ();
    slide_scan_if #(.RES_W(12), .CHNL_W(3)) bus_b ();
    slide_scan_if #(.RES_W(12), .CHNL_W(3)) bus_c ();

    slide_scan u_a (
        .clk(clk), .rst(rst), .en(en_a), .a2d(bus_a),
        .pot(pot_a), .pot_upd(upd_a), .scan_done(done_a), .timeout(to_a)
    );
    slide_scan #(.AVG_LOG2(2)) u_b (
        .clk(clk), .rst(rst), .en(en_b), .a2d(bus_b),
        .pot(pot_b), .pot_upd(upd_b), .scan_done(done_b), .timeout(to_b)
    );
    slide_scan #(.AVG_LOG2(1), .HOLDOFF(5), .TIMEOUT(64)) u_c (
        .clk(clk), .rst(rst), .en(en_c), .a2d(bus_c),
        .pot(pot_c), .pot_upd(upd_c), .scan_done(done_c), .timeout(to_c)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int now = 0;
    int t_cmplt = 0;

    // A2D model for instance A: answers 20 cycles after each request with channel*0x100.
    int a_cnt = 0;
    always @(negedge clk) begin
        bus_a.cnv_cmplt = 1'b0;
        bus_a.res       = 12'h000;
        if (a_cnt > 0) begin
            a_cnt = a_cnt - 1;
            if (a_cnt == 0) begin
                bus_a.cnv_cmplt = 1'b1;
                bus_a.res       = {1'b0, bus_a.chnnl, 8'h00};
            end
        end
        if (bus_a.strt_cnv) a_cnt = 20;
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        now++;
    endtask

    task automatic c_wait_strt();
        int t = 0;
        while (!bus_c.strt_cnv && t < 200) begin
            tick();
            t++;
        end
        check_eq("c_strt_seen", bus_c.strt_cnv, 1'b1);
    endtask

    task automatic c_sample(input logic [11:0] v);
        c_wait_strt();
        tick();
        tick();
        bus_c.cnv_cmplt = 1'b1;
        bus_c.res       = v;
        t_cmplt         = now;
        tick();
        bus_c.cnv_cmplt = 1'b0;
    endtask

    logic [2:0]  exp_seq [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7, 3'd0};
    logic [2:0]  seq [7];
    logic [11:0] b_vals [4] = '{12'hFFF, 12'hFFF, 12'hFFE, 12'hFFE};
    int          starts, writes, dones, t, t0;
    logic        seen, any;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
        bus_b.cnv_cmplt = 1'b0; bus_b.res = '0;
        bus_c.cnv_cmplt = 1'b0; bus_c.res = '0;
        repeat (3) tick();

        check_eq("rst_pot",       pot_a, 72'h0);
        check_eq("rst_upd",       upd_a, 6'h0);
        check_eq("rst_strt",      bus_a.strt_cnv, 1'b0);
        check_eq("rst_done",      done_a, 1'b0);
        check_eq("rst_timeout",   to_a, 1'b0);
        check_eq("rst_chnnl",     bus_a.chnnl, 3'd0);
        rst = 1'b0;

        // Default scan: channel order, stored values and one scan_done per six writes.
        en_a = 1'b1;
        starts = 0; writes = 0; dones = 0;
        for (int i = 0; i < 400 && starts < 7; i++) begin
            tick();
            if (upd_a != 6'h0) writes++;
            if (done_a) dones++;
            if (bus_a.strt_cnv) begin
                seq[starts] = bus_a.chnnl;
                starts++;
            end
        end
        check_eq("a_starts", starts, 7);
        for (int i = 0; i < 7; i++) check_eq($sformatf("a_chnnl_%0d", i), seq[i], exp_seq[i]);
        check_eq("a_pot", pot_a, 72'h700_400_300_200_100_000);
        check_eq("a_writes", writes, 6);
        check_eq("a_scan_done", dones, 1);

        // 4-sample average on slot 0 of instance B.
        en_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            t = 0;
            while (!bus_b.strt_cnv && t < 50) begin
                tick();
                t++;
            end
            check_eq("b_strt_seen", bus_b.strt_cnv, 1'b1);
            check_eq("b_chnnl", bus_b.chnnl, 3'd0);
            repeat (3) tick();
            bus_b.cnv_cmplt = 1'b1;
            bus_b.res       = b_vals[k];
            tick();
            bus_b.cnv_cmplt = 1'b0;
            if (k < 3) check_eq("b_upd_partial", upd_b, 6'h00);
        end
        check_eq("b_upd_final", upd_b, 6'h01);
        check_eq("b_pot0", pot_b[11:0], 12'hFFE);
        tick();
        check_eq("b_upd_single", upd_b, 6'h00);

        // Instance C: holdoff spacing and a spurious completion inside GAP.
        en_c = 1'b1;
        c_sample(12'h010);
        check_eq("c_upd_first_half", upd_c, 6'h00);
        tick();
        bus_c.cnv_cmplt = 1'b1;
        bus_c.res       = 12'hFFF;
        tick();
        bus_c.cnv_cmplt = 1'b0;
        check_eq("c_spur_upd", upd_c, 6'h00);
        c_wait_strt();
        check_eq("c_holdoff", now - t_cmplt, 6);
        check_eq("c_slot0_retained", bus_c.chnnl, 3'd0);
        c_sample(12'h030);
        check_eq("c_upd0", upd_c, 6'h01);
        check_eq("c_pot0", pot_c[11:0], 12'h020);

        // Fill slots 1..5, then slots 0..1 again; each slot s averages to {s,01}.
        for (int s = 1; s < 8; s++) begin
            c_sample({4'(s % 6), 8'h00});
            c_sample({4'(s % 6), 8'h02});
        end
        check_eq("c_pot2_before", pot_c[35:24], 12'h201);

        // Silent converter on slot 2: strt in cycle S, 64 WAIT cycles, strobe in S+65.
        c_wait_strt();
        check_eq("c_to_chnnl", bus_c.chnnl, 3'd2);
        t0 = now;
        t = 0;
        while (!to_c && t < 150) begin
            tick();
            t++;
        end
        check_eq("c_to_seen", to_c, 1'b1);
        check_eq("c_to_delay", now - t0, 65);
        check_eq("c_to_upd", upd_c, 6'h00);
        check_eq("c_pot2_kept", pot_c[35:24], 12'h201);
        c_wait_strt();
        check_eq("c_after_to_slot", bus_c.chnnl, 3'd3);

        // en dropped during the first sample of slot 3: result absorbed, no write, IDLE.
        en_c = 1'b0;
        tick();
        tick();
        bus_c.cnv_cmplt = 1'b1;
        bus_c.res       = 12'h555;
        tick();
        bus_c.cnv_cmplt = 1'b0;
        check_eq("c_endrop_upd", upd_c, 6'h00);
        check_eq("c_endrop_pot3", pot_c[47:36], 12'h301);
        any = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus_c.strt_cnv) any = 1'b1;
        end
        check_eq("c_endrop_nostrt", any, 1'b0);
        check_eq("c_endrop_idle", u_c.state_reg, IDLE);
        en_c = 1'b1;
        c_wait_strt();
        check_eq("c_resume_slot", bus_c.chnnl, 3'd3);
        c_sample(12'h400);
        check_eq("c_resume_half", upd_c, 6'h00);
        c_sample(12'h402);
        check_eq("c_resume_upd", upd_c, 6'h08);
        check_eq("c_resume_pot3", pot_c[47:36], 12'h401);

        // Reset pulsed mid-WAIT on A; the model's late completion must be ignored.
        t = 0;
        while (!bus_a.strt_cnv && t < 100) begin
            tick();
            t++;
        end
        check_eq("a_strt_before_rst", bus_a.strt_cnv, 1'b1);
        repeat (5) tick();
        rst  = 1'b1;
        en_a = 1'b0;
        tick();
        rst = 1'b0;
        check_eq("rst2_pot",     pot_a, 72'h0);
        check_eq("rst2_upd",     upd_a, 6'h0);
        check_eq("rst2_strt",    bus_a.strt_cnv, 1'b0);
        check_eq("rst2_done",    done_a, 1'b0);
        check_eq("rst2_timeout", to_a, 1'b0);
        check_eq("rst2_chnnl",   bus_a.chnnl, 3'd0);
        check_eq("rst2_state",   u_a.state_reg, IDLE);
        any  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus_a.cnv_cmplt) seen = 1'b1;
            if (bus_a.strt_cnv || upd_a != 6'h0 || done_a || to_a || pot_a != 72'h0) any = 1'b1;
        end
        check_eq("rst2_late_cmplt_sent", seen, 1'b1);
        check_eq("rst2_late_ignored", any, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
